// File: rtl/ofmap_ctrl.sv
// ofmap_ctrl: sequencer for the output-feature-map SRAM. It writes PE result vectors as 8-word
// blocks, then drains the buffer one word at a time onto a valid/ready stream toward the DMA.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; block count latched on start
// S_FILL  | accepting PE vectors, one 8-word burst write per handshake
// S_DRAIN | issuing single-word reads, streaming through a 2-entry FIFO
// S_DONE  | one-cycle done pulse, then back to idle
module ofmap_ctrl #(
    parameter int ADDR_BIT = 7
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [ADDR_BIT-4:0] cfg_blocks_m1,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data [0:7],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_BIT-1:0] sram_addr,
    output logic                sram_en,
    output logic                sram_we,
    output logic [31:0]         sram_di [0:7],
    input  logic [31:0]         sram_do
);

    localparam int BLK_W = ADDR_BIT - 3;
    localparam int NB_W  = ADDR_BIT - 2;
    localparam int CNT_W = ADDR_BIT + 1;

    localparam logic [NB_W-1:0]     NB_ONE    = 1;
    localparam logic [BLK_W-1:0]    BLK_ONE   = 1;
    localparam logic [CNT_W-1:0]    CNT_ONE   = 1;
    localparam logic [ADDR_BIT-1:0] BLK_WORDS = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [BLK_W-1:0]    r_blk_m1;
    logic [BLK_W-1:0]    r_blk_cnt;
    logic [ADDR_BIT-1:0] r_wptr;
    logic [CNT_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_pop_cnt;
    logic                r_pend;
    logic [1:0]          r_occ;
    logic [31:0]         r_head;
    logic [31:0]         r_tail;

    logic [NB_W-1:0]  w_nblk;
    logic [CNT_W-1:0] w_nwords;
    logic [CNT_W-1:0] w_last_word;
    logic             w_wr_hs;
    logic             w_pop;
    logic             w_push;
    logic [2:0]       w_lvl;
    logic             w_issue;

    assign w_nblk      = {1'b0, r_blk_m1} + NB_ONE;
    assign w_nwords    = {w_nblk, 3'b000};
    assign w_last_word = w_nwords - CNT_ONE;

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_head;

    assign w_wr_hs = (r_state == S_FILL) && in_valid && !RST;
    assign w_pop   = out_valid && out_ready;
    assign w_push  = r_pend;

    // Buffered-plus-in-flight level after this cycle's pop; a new read must keep it within 2.
    assign w_lvl   = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue = (r_state == S_DRAIN) && !RST && (r_rptr < w_nwords) && (w_lvl < 3'd2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                if (in_valid && (r_blk_cnt == r_blk_m1)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_pop_cnt == w_last_word)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        sram_we   = 1'b0;
        sram_en   = 1'b0;
        sram_addr = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_FILL: begin
                in_ready  = !RST;
                sram_we   = w_wr_hs;
                sram_addr = r_wptr;
            end
            S_DRAIN: begin
                sram_en = w_issue;
                if (w_issue) begin
                    sram_addr = r_rptr[ADDR_BIT-1:0];
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            sram_di[k] = in_data[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_blk_m1  <= '0;
            r_blk_cnt <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_pop_cnt <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_pend <= w_issue;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_blk_m1  <= cfg_blocks_m1;
                        r_blk_cnt <= '0;
                        r_wptr    <= '0;
                        r_rptr    <= '0;
                        r_pop_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        r_wptr    <= r_wptr + BLK_WORDS;
                        r_blk_cnt <= r_blk_cnt + BLK_ONE;
                    end
                end
                S_DRAIN: begin
                    if (w_issue) begin
                        r_rptr <= r_rptr + CNT_ONE;
                    end
                    if (w_pop) begin
                        r_pop_cnt <= r_pop_cnt + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Shift-style FIFO: r_head is always the word on out_data, so it holds while stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= sram_do;
                    end else begin
                        r_tail <= sram_do;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= sram_do;
                    end else begin
                        r_head <= sram_do;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofmap_ctrl.sv
// Directed bench for ofmap_ctrl with a behavioural SRAM and a word-order scoreboard.
module tb_ofmap_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [3:0]  cfg_blocks_m1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data [0:7];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [6:0]  sram_addr;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_di [0:7];
    logic [31:0] sram_do;

    logic [31:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [6:0]  exp_wptr = '0;
    int wr_cnt = 0, pops = 0, done_cnt = 0, lvl = 0, cyc = 0;
    int first_we_cyc = 0, last_we_cyc = 0, first_ov_cyc = 0, done_cyc = 0;
    bit seen_ov = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    int n;

    ofmap_ctrl #(.ADDR_BIT(7)) dut (
        .CLK(CLK), .RST(RST), .start(start), .cfg_blocks_m1(cfg_blocks_m1),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .sram_addr(sram_addr), .sram_en(sram_en),
        .sram_we(sram_we), .sram_di(sram_di), .sram_do(sram_do)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (sram_we) begin
            for (int k = 0; k < 8; k++) mem[sram_addr + 7'(k)] <= sram_di[k];
        end
        if (sram_en) sram_do <= mem[sram_addr];
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    // Monitor: write addresses, scoreboard pops, stall hold, in-flight bound, done pulses.
    always @(negedge CLK) begin
        check("we_en_exclusive", 32'(sram_we && sram_en), 32'd0);
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (sram_we) begin
                check("wr_addr", 32'(sram_addr), 32'(exp_wptr));
                exp_wptr = exp_wptr + 7'd8;
                if (wr_cnt == 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
                wr_cnt++;
            end
            if (out_valid && !seen_ov) begin
                seen_ov = 1'b1;
                first_ov_cyc = cyc;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", out_data, prev_data);
            end
            if (sram_en) lvl++;
            if (out_valid && out_ready) begin
                pops++;
                lvl--;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL out_extra: observed word %0h, expected no word", out_data);
                end
                if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
            end
            check("inflight_le2", 32'(lvl <= 2), 32'd1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send_vec(input logic [31:0] base);
        int w = 0;
        for (int k = 0; k < 8; k++) in_data[k] = base + 32'(k);
        in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) exp_q.push_back(base + 32'(k));
        @(posedge CLK); #1;
    endtask

    task automatic start_fill(input int m1, input logic [31:0] base, input bit gaps, input bit poke);
        exp_wptr = '0; wr_cnt = 0; seen_ov = 1'b0; done_cnt = 0; pops = 0; lvl = 0;
        cfg_blocks_m1 = 4'(m1);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cfg_blocks_m1 = 4'($urandom);
        check("fill_in_ready", 32'(in_ready), 32'd1);
        check("fill_busy", 32'(busy), 32'd1);
        for (int b = 0; b <= m1; b++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            end
            if (poke && b == 1) begin
                start = 1'b1;
                cfg_blocks_m1 = 4'd0;
            end
            send_vec(base + 32'(b * 8));
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_wait(input bit rnd, input bit poke);
        int w = 0;
        while (done_cnt == 0 && w < 3000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke && (w == 4);
            @(posedge CLK); #1;
            w++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", 32'(w < 3000), 32'd1);
        repeat (3) begin @(posedge CLK); #1; end
        check("done_once", 32'(done_cnt), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        check("valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset with random inputs
        RST = 1'b1;
        start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
        cfg_blocks_m1 = 4'($urandom);
        for (int k = 0; k < 8; k++) in_data[k] = $urandom;
        repeat (2) begin
            @(posedge CLK); #1;
            start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
            for (int k = 0; k < 8; k++) in_data[k] = $urandom;
            @(negedge CLK);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", out_data, 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sram_en", 32'(sram_en), 32'd0);
            check("rst_sram_we", 32'(sram_we), 32'd0);
            check("rst_sram_addr", 32'(sram_addr), 32'd0);
        end
        @(posedge CLK); #1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_blocks_m1 = '0;
        RST = 1'b0;
        @(posedge CLK); #1;

        // 2: single block, timing
        start_fill(0, 32'h100, 1'b0, 1'b0);
        drain_wait(1'b0, 1'b0);
        check("single_wr_cnt", 32'(wr_cnt), 32'd1);
        check("single_first_valid", 32'(first_ov_cyc - last_we_cyc), 32'd3);
        check("single_done_cyc", 32'(done_cyc - last_we_cyc), 32'd11);

        // 3: full buffer, back-to-back writes
        start_fill(15, 32'h0, 1'b0, 1'b0);
        drain_wait(1'b0, 1'b0);
        check("full_wr_cnt", 32'(wr_cnt), 32'd16);
        check("full_wr_consec", 32'(last_we_cyc - first_we_cyc), 32'd15);
        check("full_done_cyc", 32'(done_cyc - last_we_cyc), 32'd131);

        // 4: backpressure and input gaps
        start_fill(3, 32'h5000, 1'b1, 1'b0);
        drain_wait(1'b1, 1'b0);
        check("bp_wr_cnt", 32'(wr_cnt), 32'd4);
        check("bp_pops", 32'(pops), 32'd32);

        // 5: ignored inputs
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) in_data[k] = $urandom;
        repeat (3) begin
            @(negedge CLK);
            check("idle_no_we", 32'(sram_we), 32'd0);
            check("idle_no_ready", 32'(in_ready), 32'd0);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        start_fill(1, 32'hA000, 1'b0, 1'b1);
        drain_wait(1'b0, 1'b1);
        check("poke_wr_cnt", 32'(wr_cnt), 32'd2);
        check("poke_pops", 32'(pops), 32'd16);

        // 6: reset in the middle of a drain
        start_fill(0, 32'h7700, 1'b0, 1'b0);
        out_ready = 1'b1;
        n = 0;
        while (pops < 5 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("pop5_seen", 32'(n < 100), 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sram_en", 32'(sram_en), 32'd0);
        check("mid_rst_pops", 32'(pops), 32'd5);
        exp_q.delete();
        lvl = 0;
        RST = 1'b0;
        @(posedge CLK); #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        start_fill(0, 32'hBEE0, 1'b0, 1'b0);
        drain_wait(1'b0, 1'b0);
        check("post_rst_wr_cnt", 32'(wr_cnt), 32'd1);
        check("post_rst_pops", 32'(pops), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofmap_ctrl.md
# ofmap_ctrl

Sequencer for the output-feature-map SRAM (32-bit words, 8-word burst write, single-word read with 1-cycle latency). It accepts 8-lane result vectors from the PE array and writes them as consecutive 8-word blocks. It then drains the buffer word by word onto a valid/ready stream toward the DMA. It owns the SRAM's single address port and signals completion with a one-cycle `done` pulse.

## Interface
- `ADDR_BIT`, 7, SRAM word-address width. Capacity is 2^ADDR_BIT words, i.e. 2^(ADDR_BIT-3) blocks.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `RST`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a job; sampled only in IDLE
- `cfg_blocks_m1`  in  ADDR_BIT-3  number of 8-word blocks minus 1; sampled with `start`
- `in_valid`  in  1  PE result vector valid
- `in_ready`  out  1  controller accepts a vector
- `in_data`  in  32 x [0:7]  lane k goes to word k of the block
- `out_valid`  out  1  drain word valid
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  32  drain word
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at job end
- `sram_addr`  out  ADDR_BIT  SRAM address
- `sram_en`  out  1  SRAM read enable
- `sram_we`  out  1  SRAM 8-word burst write enable
- `sram_di`  out  32 x [0:7]  SRAM write data
- `sram_do`  in  32  SRAM read data; valid the cycle after `sram_en`

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE
  - `start` -> FILL.
  - Latch nblk = `cfg_blocks_m1`+1. Clear wptr, rptr, blocks-written count and words-popped count.
  - `in_valid` is ignored; `in_ready`=0.
- FILL
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` the same cycle drives `sram_we`=1, `sram_addr`=wptr and `sram_di`=`in_data` (combinational), then wptr += 8.
  - On the handshake for block nblk-1 -> DRAIN.
- DRAIN
  - `in_ready`=0. The output buffer is a 2-entry FIFO holding SRAM read data. pend = a read issued last cycle. pop = `out_valid`&&`out_ready`.
  - Issue a read (`sram_en`=1, `sram_addr`=rptr, rptr++) when rptr < 8*nblk and occ + pend - pop < 2.
  - The returning `sram_do` is pushed into the FIFO the cycle after issue.
  - `out_valid` = FIFO non-empty. `out_data` = FIFO head, registered and stable while `out_valid`&&!`out_ready`.
  - On the pop of word 8*nblk-1 -> DONE.
- DONE
  - `done`=1 for one cycle, then -> IDLE.
- `sram_we` and `sram_en` are never both 1. Both are 0 in IDLE and DONE, and while `RST`=1.
- Words appear on `out_data` in address order 0..8*nblk-1. There is no loss, duplication or wrap: the maximum address is 2^ADDR_BIT-1.
- `start` outside IDLE is ignored.
- Reset mid-job
  - The next edge returns to IDLE. The FIFO is flushed, and any in-flight read is discarded.
  - SRAM contents are not cleared.

## Timing
- Reset values: state IDLE; `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0; all pointers and counters 0.
- `start` in cycle S -> FILL in S+1, with `in_ready`=1 in S+1.
- A write handshake in cycle N updates SRAM at the edge ending N.
- If the last write is in cycle N:
  - DRAIN in N+1, with the first read issued in N+1;
  - the first `out_valid` in N+3.
- With `out_ready` held at 1 the drain runs at 1 word/cycle. The last word is in N+2+8*nblk, and `done`=1 in N+3+8*nblk.
- At most 2 words are buffered plus in flight: no FIFO overflow under any `out_ready` pattern.

## Test plan
1. Reset: assert `RST` 2 cycles with random inputs -> all outputs at their reset values; `sram_we`=`sram_en`=0 throughout.
2. Single block: `cfg_blocks_m1`=0, lane k = 0x100+k, `out_ready`=1 -> one write at addr 0; `out_data` = 0x100..0x107 on 8 consecutive cycles starting N+3; `done` pulse at N+11.
3. Full buffer: `cfg_blocks_m1`=15, block b lane k = b*8+k, `in_valid` and `out_ready` always 1 -> 16 writes at addr 0,8,..,120 on consecutive cycles; 128 words 0..127 at 1/cycle; `done` once.
4. Backpressure: 4 blocks, random `out_ready` (50%) and gaps in `in_valid` -> output sequence exact and in order; `out_data` holds while stalled; FIFO never exceeds 2.
5. Ignored inputs: `in_valid`=1 in IDLE, and `start` pulsed during FILL and DRAIN -> no writes in IDLE; the job proceeds unchanged, with exactly one `done`.
6. Reset mid-DRAIN: assert `RST` after 5 words popped -> IDLE next edge, `out_valid`=0; a new 1-block job then runs correctly from addr 0.
